// File: rtl/rtc_regs_pkg.sv
// Register map, status bit positions and BCD limits of the RTC bus responder.
package rtc_regs_pkg;

   localparam logic [7:0] ADDR_STATUS = 8'h00;
   localparam logic [7:0] ADDR_SEC    = 8'h21;
   localparam logic [7:0] ADDR_MIN    = 8'h22;
   localparam logic [7:0] ADDR_HOUR   = 8'h23;
   localparam logic [7:0] ADDR_DAY    = 8'h24;
   localparam logic [7:0] ADDR_MONTH  = 8'h25;
   localparam logic [7:0] ADDR_YEAR   = 8'h26;
   localparam logic [7:0] ADDR_WDAY   = 8'h27;
   localparam logic [7:0] ADDR_TSEC   = 8'h41;
   localparam logic [7:0] ADDR_TMIN   = 8'h42;
   localparam logic [7:0] ADDR_THOUR  = 8'h43;

   localparam int unsigned ST_DONE = 0;
   localparam int unsigned ST_TEN  = 1;
   localparam int unsigned ST_IEN  = 2;

   localparam logic [7:0] BCD_MAX_MS = 8'h59;
   localparam logic [7:0] BCD_MAX_HR = 8'h23;

endpackage

// File: rtl/bcd_digit_pair.sv
// Two-digit BCD register with bus load, increment/decrement and wrap carry.
module bcd_digit_pair
   import rtc_regs_pkg::*;
#(
   parameter logic [7:0] LIMIT = BCD_MAX_MS
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_load,
   input  logic [7:0] i_load_val,
   input  logic       i_inc,
   input  logic       i_dec,
   output logic [7:0] o_val,
   output logic       o_cy_c
);

   logic [7:0] r_val;
   logic [7:0] w_next;
   logic [3:0] w_lo;
   logic [3:0] w_hi;

   assign w_lo   = r_val[3:0];
   assign w_hi   = r_val[7:4];
   assign o_val  = r_val;
   // Carry on increment past the limit, borrow on decrement below zero.
   assign o_cy_c = (i_inc & (r_val == LIMIT)) | (i_dec & (r_val == 8'h00));

   // Nibble-wise BCD step; out-of-range values simply follow the same rules.
   always_comb begin
      w_next = r_val;
      if (i_inc) begin
         if (r_val == LIMIT)     w_next = 8'h00;
         else if (w_lo == 4'h9)  w_next = {w_hi + 4'd1, 4'h0};
         else                    w_next = {w_hi, w_lo + 4'd1};
      end else if (i_dec) begin
         if (r_val == 8'h00)     w_next = LIMIT;
         else if (w_lo == 4'h0)  w_next = {w_hi - 4'd1, 4'h9};
         else                    w_next = {w_hi, w_lo - 4'd1};
      end
   end

   // Bus load has priority over counting.
   always_ff @(posedge clk) begin
      if (reset)       r_val <= 8'h00;
      else if (i_load) r_val <= i_load_val;
      else             r_val <= w_next;
   end

endmodule

// File: rtl/rtc_bus_responder.sv
// RTC chip model: multiplexed-bus slave, BCD wall clock and countdown timer.
module rtc_bus_responder
   import rtc_regs_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       CS,
   input  logic       AD,
   input  logic       RD,
   input  logic       WR,
   input  logic [7:0] DatAdd_in,
   output logic [7:0] DatAdd_out,
   output logic       DatAdd_oe,
   output logic       IRQ
);

   localparam int unsigned   PW         = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] r_presc;
   logic          r_tick_pend;
   logic [7:0]    r_addr, r_wr_cap;
   logic          r_wr_prev, r_rd_prev, r_wr_err;
   logic          r_done, r_tim_en, r_irq_en;
   logic [7:0]    r_day, r_month, r_year, r_wday;
   logic [7:0]    r_dout;
   logic          r_oe, r_irq;

   logic       w_wr_ok, w_addr_commit, w_data_commit;
   logic       w_tick, w_tick_any, w_do_tick;
   logic       w_tmr_dec, w_tmr_hit, w_st_wr;
   logic       w_done_nxt, w_tim_en_nxt, w_irq_en_nxt;
   logic       w_rd_start, w_rd_hold;
   logic [7:0] w_rd_data;
   logic [7:0] w_sec, w_min, w_hour, w_tsec, w_tmin, w_thour;
   logic       w_cy_sec, w_cy_min, w_cy_hour, w_cy_tsec, w_cy_tmin, w_cy_thour;
   logic       w_unused_cy;

   // WR rising edge under CS commits, unless RD collided with this strobe.
   assign w_wr_ok       = ~CS & ~r_wr_prev & WR & RD & ~r_wr_err;
   assign w_addr_commit = w_wr_ok & ~AD;
   assign w_data_commit = w_wr_ok & AD;
   assign w_st_wr       = w_data_commit & (r_addr == ADDR_STATUS);

   // A tick that meets a data write waits one cycle so the write wins.
   assign w_tick     = (r_presc == PRESC_LAST);
   assign w_tick_any = w_tick | r_tick_pend;
   assign w_do_tick  = w_tick_any & ~w_data_commit;

   assign w_tmr_dec = w_do_tick & r_tim_en & ((w_tsec | w_tmin | w_thour) != 8'h00);
   assign w_tmr_hit = w_tmr_dec & (w_tsec == 8'h01) & (w_tmin == 8'h00) & (w_thour == 8'h00);

   assign w_done_nxt   = w_st_wr ? (r_done & ~r_wr_cap[ST_DONE]) : (r_done | w_tmr_hit);
   assign w_tim_en_nxt = w_st_wr ? r_wr_cap[ST_TEN] : r_tim_en;
   assign w_irq_en_nxt = w_st_wr ? r_wr_cap[ST_IEN] : r_irq_en;

   assign w_rd_start = ~CS & AD & ~RD & WR & r_rd_prev;
   assign w_rd_hold  = ~CS & ~RD & WR;

   // Hour carry and timer-hour borrow have no consumer.
   assign w_unused_cy = w_cy_hour | w_cy_thour;

   bcd_digit_pair #(.LIMIT(BCD_MAX_MS)) u_sec (
      .clk(clk), .reset(reset), .i_load(w_data_commit & (r_addr == ADDR_SEC)),
      .i_load_val(r_wr_cap), .i_inc(w_do_tick), .i_dec(1'b0), .o_val(w_sec), .o_cy_c(w_cy_sec));
   bcd_digit_pair #(.LIMIT(BCD_MAX_MS)) u_min (
      .clk(clk), .reset(reset), .i_load(w_data_commit & (r_addr == ADDR_MIN)),
      .i_load_val(r_wr_cap), .i_inc(w_cy_sec), .i_dec(1'b0), .o_val(w_min), .o_cy_c(w_cy_min));
   bcd_digit_pair #(.LIMIT(BCD_MAX_HR)) u_hour (
      .clk(clk), .reset(reset), .i_load(w_data_commit & (r_addr == ADDR_HOUR)),
      .i_load_val(r_wr_cap), .i_inc(w_cy_min), .i_dec(1'b0), .o_val(w_hour), .o_cy_c(w_cy_hour));
   bcd_digit_pair #(.LIMIT(BCD_MAX_MS)) u_tsec (
      .clk(clk), .reset(reset), .i_load(w_data_commit & (r_addr == ADDR_TSEC)),
      .i_load_val(r_wr_cap), .i_inc(1'b0), .i_dec(w_tmr_dec), .o_val(w_tsec), .o_cy_c(w_cy_tsec));
   bcd_digit_pair #(.LIMIT(BCD_MAX_MS)) u_tmin (
      .clk(clk), .reset(reset), .i_load(w_data_commit & (r_addr == ADDR_TMIN)),
      .i_load_val(r_wr_cap), .i_inc(1'b0), .i_dec(w_cy_tsec), .o_val(w_tmin), .o_cy_c(w_cy_tmin));
   bcd_digit_pair #(.LIMIT(BCD_MAX_HR)) u_thour (
      .clk(clk), .reset(reset), .i_load(w_data_commit & (r_addr == ADDR_THOUR)),
      .i_load_val(r_wr_cap), .i_inc(1'b0), .i_dec(w_cy_tmin), .o_val(w_thour), .o_cy_c(w_cy_thour));

   // Register file read mux; unmapped addresses read as zero.
   always_comb begin
      w_rd_data = 8'h00;
      case (r_addr)
         ADDR_STATUS: w_rd_data = {5'b00000, r_irq_en, r_tim_en, r_done};
         ADDR_SEC:    w_rd_data = w_sec;
         ADDR_MIN:    w_rd_data = w_min;
         ADDR_HOUR:   w_rd_data = w_hour;
         ADDR_DAY:    w_rd_data = r_day;
         ADDR_MONTH:  w_rd_data = r_month;
         ADDR_YEAR:   w_rd_data = r_year;
         ADDR_WDAY:   w_rd_data = r_wday;
         ADDR_TSEC:   w_rd_data = w_tsec;
         ADDR_TMIN:   w_rd_data = w_tmin;
         ADDR_THOUR:  w_rd_data = w_thour;
         default:     w_rd_data = 8'h00;
      endcase
   end

   // Bus decoder, prescaler, storage-only registers, status and read driver.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_presc     <= '0;
         r_tick_pend <= 1'b0;
         r_addr      <= 8'h00;
         r_wr_cap    <= 8'h00;
         r_wr_prev   <= 1'b1;
         r_rd_prev   <= 1'b1;
         r_wr_err    <= 1'b0;
         r_done      <= 1'b0;
         r_tim_en    <= 1'b0;
         r_irq_en    <= 1'b0;
         r_day       <= 8'h00;
         r_month     <= 8'h00;
         r_year      <= 8'h00;
         r_wday      <= 8'h00;
         r_dout      <= 8'h00;
         r_oe        <= 1'b0;
         r_irq       <= 1'b1;
      end else begin
         r_wr_prev <= WR;
         r_rd_prev <= RD;
         if (~CS & ~WR) r_wr_cap <= DatAdd_in;
         if (~CS & ~WR & ~RD) r_wr_err <= 1'b1;
         else if (WR)         r_wr_err <= 1'b0;

         if (w_addr_commit) r_addr <= r_wr_cap;
         if (w_data_commit) begin
            case (r_addr)
               ADDR_DAY:   r_day   <= r_wr_cap;
               ADDR_MONTH: r_month <= r_wr_cap;
               ADDR_YEAR:  r_year  <= r_wr_cap;
               ADDR_WDAY:  r_wday  <= r_wr_cap;
               default:    ;
            endcase
         end

         if (w_data_commit && (r_addr == ADDR_SEC)) r_presc <= '0;
         else if (w_tick)                           r_presc <= '0;
         else                                       r_presc <= r_presc + PW'(1);
         r_tick_pend <= w_tick_any & w_data_commit;

         r_done   <= w_done_nxt;
         r_tim_en <= w_tim_en_nxt;
         r_irq_en <= w_irq_en_nxt;
         r_irq    <= ~(w_done_nxt & w_irq_en_nxt);

         if (w_rd_start) begin
            r_dout <= w_rd_data;
            r_oe   <= 1'b1;
         end else if (r_oe && !w_rd_hold) begin
            r_dout <= 8'h00;
            r_oe   <= 1'b0;
         end
      end
   end

   assign DatAdd_out = r_dout;
   assign DatAdd_oe  = r_oe;
   assign IRQ        = r_irq;

endmodule

// File: doc/rtc_bus_responder.md
# rtc_bus_responder

Bus-slave model of the external real-time-clock chip, sitting on the far end of the multiplexed CS/AD/RD/WR/DatAdd bus driven by the RTC controller. It holds the RTC register file, counts wall-clock time and a countdown timer in BCD, and answers address, write and read cycles exactly as the chip does. The controller can then be verified in closed loop and brought up on the FPGA without the physical chip.

## Interface
- TICK_DIV, 100000000: clk cycles per one-second tick; ≥2.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- CS  in  1  chip select, active-low.
- AD  in  1  0 = address phase, 1 = data phase.
- RD  in  1  read strobe, active-low.
- WR  in  1  write strobe, active-low.
- DatAdd_in  in  8  address/data from initiator.
- DatAdd_out  out  8  read data to initiator.
- DatAdd_oe  out  1  1 while responder drives the bus.
- IRQ  out  1  active-low timer interrupt.

## Operation
- Register map (BCD): 0x00 status/control; 0x21 sec, 0x22 min, 0x23 hour (24 h); 0x24 day, 0x25 month, 0x26 year, 0x27 weekday (storage only, no carry); 0x41 timer sec, 0x42 timer min, 0x43 timer hour. Status bits: bit0 done (write 1 clears), bit1 timer enable, bit2 irq enable; bits 7:3 read 0.
- Unmapped addresses: reads return 0x00; writes are ignored.
- Bus decode, all qualified by CS=0. RD=0 and WR=0 together is a protocol error: no write and no drive.
  - WR low cycles: DatAdd_in is captured every cycle.
  - WR rising edge (prev 0, now 1) with AD=0: the captured byte goes to the address latch.
  - WR rising edge with AD=1: the captured byte is written to reg[address latch].
- Read: on the first sampled cycle with CS=0, AD=1, RD=0, reg[address latch] is snapshotted into DatAdd_out and DatAdd_oe is set. The value is held until RD=1 or CS=1. The snapshot is coherent even if a tick lands during the strobe.
- CS=1: strobes are ignored. Edge detectors still track WR and RD.
- Clock tick at prescaler terminal count:
  - Seconds increment.
  - Each pair uses nibble rules: 0x59→0x00 with carry; low nibble 9→high+1, low 0; else low+1.
  - Carries ripple sec→min→hour. Hour wraps 0x23→0x00.
- Timer on tick, only when enabled and the value is non-zero: BCD decrement with borrow (0x00→0x59). Reaching 00:00:00 sets done.
- Writing to 0x21 clears the prescaler.
- Out-of-range BCD values are stored as written and then follow the nibble rules.
- IRQ = ~(done & irq_en).

## Timing
- Reset values:
  - All registers 0x00, address latch 0x00, prescaler 0.
  - Edge-detector history 1 (inactive).
  - DatAdd_out 0x00, DatAdd_oe 0, IRQ 1.
- Write latency: the register or latch is updated at the clock edge after the WR-rising detection cycle.
- Read latency: DatAdd_out and DatAdd_oe are valid one cycle after RD is first sampled low. They drop one cycle after RD or CS is sampled high.
- A tick coinciding with a data-write commit is deferred one cycle through a pending flag, so the write always wins and no tick is lost.
- Reset mid-cycle aborts any transaction. The first WR edge after reset needs a fresh low→high transition.

## Structure
- Package rtc_regs_pkg: register address constants, status bit indices, BCD limits (0x59, 0x23).
- Sub-module bcd_digit_pair: 8-bit BCD pair with inc/dec, programmable wrap limit, carry/borrow out. Instantiated for the three clock pairs and three timer pairs.
- Top level contains the bus decoder, the register file mux and the prescaler.

## Test plan
- Address/write/read: with TICK_DIV=1000, write addr 0x22, then data 0x37, then read back → DatAdd_out=0x37 and oe=1 one cycle after RD low. oe returns to 0 after RD high.
- Clock rollover: with TICK_DIV=4, set 23:59:59, wait 4 cycles → 00:00:00. Day register is unchanged.
- Timer: set timer 00:00:02, status 0x06, with TICK_DIV=4. After 8 cycles done=1 and IRQ=0. Write 0x07 to 0x00 → done=0 and IRQ=1.
- Conflicts: tick in the same cycle as a write of 0x10 to 0x21 → sec=0x10, then 0x11 one cycle later. RD and WR low together → no write, oe=0.
- Boundary: unmapped read 0x55 → 0x00. CS=1 strobes → no effect. Reset asserted mid-read → oe=0 and all registers 0x00 on the next cycle.
